s1_share_arbiter: RTL and testbench

- Round-robin controller that shares one N-bit s1-cell register among 4 requesters.
- Drives the cell's 2-bit mux select and clear. Requesters place data on the D0..D3 mux inputs; the arbiter picks which one the register captures each cycle.
- Bounds each ownership to MAX_HOLD cycles.
- Handles flush (clear) requests, which take priority over grants.

---
 rtl/s1_share_arbiter_pkg.sv | 18 +
 rtl/s1_share_arbiter_rr_pick.sv | 23 ++
 rtl/s1_share_arbiter.sv | 135 +++++++++++++
 tb/tb_s1_share_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/s1_share_arbiter_pkg.sv
// Shared types and constants for the s1-cell share arbiter.
package s1_share_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    CLEAR = 2'b10
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/s1_share_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr, wrapping mod 4.
module rr_pick
  import s1_share_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s1_share_arbiter.sv
// Round-robin owner of one shared s1-cell register among 4 requesters.
// Drives the cell mux select and a one-cycle clear; flush beats any grant.
//
//   state | meaning
//   IDLE  | no owner, clr_o low, sel keeps last owner
//   GRANT | sel/gnt name the owner, bounded to MAX_HOLD cycles
//   CLEAR | one-cycle clr_o pulse to the shared register, no grant
module s1_share_arbiter
  import s1_share_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [NREQ-1:0]  req,
  input  logic             flush,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             clr_o,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [SEL_W-1:0] idx_cur;
  logic             any_cur;
  logic [SEL_W-1:0] ptr_rot;
  logic [SEL_W-1:0] idx_rot;
  logic             any_rot;
  logic             release_own;

  // Arbitration from IDLE uses the stored pointer.
  rr_pick u_pick_cur (
    .req (req),
    .ptr (ptr),
    .idx (idx_cur),
    .any (any_cur)
  );

  // Back-to-back handover arbitrates as if ptr had already moved past the owner,
  // so the outgoing owner only wins again when nobody else is asking.
  assign ptr_rot = sel + SEL_W'(1);

  rr_pick u_pick_rot (
    .req (req),
    .ptr (ptr_rot),
    .idx (idx_rot),
    .any (any_rot)
  );

  // sel holds the owner index throughout GRANT.
  assign release_own = !req[sel] || (hold_cnt == HOLD_LAST) || flush;

  // Sequencer: state, pointer, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      clr_o    <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state <= CLEAR;
            gnt   <= '0;
            clr_o <= 1'b1;
            busy  <= 1'b1;
          end else if (any_cur) begin
            state    <= GRANT;
            gnt      <= onehot(idx_cur);
            sel      <= idx_cur;
            clr_o    <= 1'b0;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            gnt   <= '0;
            clr_o <= 1'b0;
            busy  <= 1'b0;
          end
        end

        GRANT: begin
          if (release_own) begin
            ptr      <= ptr_rot;
            hold_cnt <= '0;
            if (flush) begin
              state <= CLEAR;
              gnt   <= '0;
              clr_o <= 1'b1;
              busy  <= 1'b1;
            end else if (any_rot) begin
              state <= GRANT;
              gnt   <= onehot(idx_rot);
              sel   <= idx_rot;
              clr_o <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              clr_o <= 1'b0;
              busy  <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        CLEAR: begin
          state <= IDLE;
          gnt   <= '0;
          clr_o <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          gnt      <= '0;
          clr_o    <= 1'b0;
          busy     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s1_share_arbiter.sv
// Bench for s1_share_arbiter: three instances (MAX_HOLD 4, 2, 1) on shared inputs,
// a directed vector table, hand sequences and random traffic against a model.
module tb_s1_share_arbiter;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       flush = 1'b0;

  logic [3:0] gnt0, gnt1, gnt2;
  logic [1:0] sel0, sel1, sel2;
  logic       clr0, clr1, clr2;
  logic       busy0, busy1, busy2;

  always #5 clk = ~clk;

  s1_share_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u_dut0 (
    .clk(clk), .clr_n(clr_n), .req(req), .flush(flush),
    .gnt(gnt0), .sel(sel0), .clr_o(clr0), .busy(busy0));

  s1_share_arbiter #(.MAX_HOLD(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .req(req), .flush(flush),
    .gnt(gnt1), .sel(sel1), .clr_o(clr1), .busy(busy1));

  s1_share_arbiter #(.MAX_HOLD(1), .CNT_W(1)) u_dut2 (
    .clk(clk), .clr_n(clr_n), .req(req), .flush(flush),
    .gnt(gnt2), .sel(sel2), .clr_o(clr2), .busy(busy2));

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = no owner, 1 = owned, 2 = clearing.
  int hold_lim[3] = '{4, 2, 1};
  int ph[3];
  int own[3];
  int used[3];
  int ptr_m[3];
  int sel_m[3];

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      ph[m] = 0; own[m] = 0; used[m] = 0; ptr_m[m] = 0; sel_m[m] = 0;
    end
  endtask

  task automatic model_step();
    int w;
    for (int m = 0; m < 3; m++) begin
      if (ph[m] == 2) begin
        ph[m] = 0;
      end else if (ph[m] == 0) begin
        if (flush) ph[m] = 2;
        else begin
          w = pick(req, ptr_m[m]);
          if (w >= 0) begin ph[m] = 1; own[m] = w; sel_m[m] = w; used[m] = 1; end
        end
      end else begin
        if (!req[own[m]] || used[m] == hold_lim[m] || flush) begin
          ptr_m[m] = (own[m] + 1) % 4;
          if (flush) ph[m] = 2;
          else begin
            w = pick(req, ptr_m[m]);
            if (w >= 0) begin own[m] = w; sel_m[m] = w; used[m] = 1; end
            else ph[m] = 0;
          end
        end else begin
          used[m] = used[m] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_models();
    logic [3:0] g; logic [1:0] s; logic c; logic b;
    logic [3:0] eg;
    for (int m = 0; m < 3; m++) begin
      case (m)
        0: begin g = gnt0; s = sel0; c = clr0; b = busy0; end
        1: begin g = gnt1; s = sel1; c = clr1; b = busy1; end
        default: begin g = gnt2; s = sel2; c = clr2; b = busy2; end
      endcase
      eg = (ph[m] == 1) ? (4'b0001 << own[m]) : 4'b0000;
      chk($sformatf("model_gnt%0d", m), 8'(g), 8'(eg));
      chk($sformatf("model_sel%0d", m), 8'(s), 8'(sel_m[m]));
      chk($sformatf("model_clr%0d", m), 8'(c), 8'(ph[m] == 2));
      chk($sformatf("model_busy%0d", m), 8'(b), 8'(ph[m] != 0));
      chk($sformatf("inv_onehot%0d", m), 8'($onehot0(g)), 8'd1);
      chk($sformatf("inv_excl%0d", m), 8'(c && (|g)), 8'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_models();
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    req   = 4'b0000;
    flush = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    check_models();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       flush;
    logic [3:0] g;
    logic [1:0] s;
    logic       c;
    logic       b;
  } vec_t;

  vec_t tbl[33];

  task automatic set_row(input int i, input logic [3:0] r, input logic f,
                         input logic [3:0] g, input logic [1:0] s,
                         input logic c, input logic b);
    tbl[i].req = r; tbl[i].flush = f; tbl[i].g = g;
    tbl[i].s = s; tbl[i].c = c; tbl[i].b = b;
  endtask

  initial begin
    int n;
    logic [3:0] rot_exp[5];
    int o;

    // Directed rows for the MAX_HOLD=4 instance, starting from reset.
    set_row(0,  4'b0100, 0, 4'b0100, 2'd2, 0, 1);
    set_row(1,  4'b0100, 0, 4'b0100, 2'd2, 0, 1);
    set_row(2,  4'b0000, 0, 4'b0000, 2'd2, 0, 0);
    set_row(3,  4'b0001, 1, 4'b0000, 2'd2, 1, 1);
    set_row(4,  4'b0001, 0, 4'b0000, 2'd2, 0, 0);
    set_row(5,  4'b0001, 0, 4'b0001, 2'd0, 0, 1);
    set_row(6,  4'b1000, 0, 4'b1000, 2'd3, 0, 1);
    set_row(7,  4'b1001, 1, 4'b0000, 2'd3, 1, 1);
    set_row(8,  4'b1001, 0, 4'b0000, 2'd3, 0, 0);
    set_row(9,  4'b1001, 0, 4'b0001, 2'd0, 0, 1);
    for (int i = 10; i < 13; i++) set_row(i, 4'b1111, 0, 4'b0001, 2'd0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      o = (1 + k / 4) % 4;
      set_row(13 + k, 4'b1111, 0, 4'b0001 << o, 2'(o), 0, 1);
    end
    set_row(29, 4'b0000, 1, 4'b0000, 2'd0, 1, 1);
    set_row(30, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
    set_row(31, 4'b0000, 1, 4'b0000, 2'd0, 1, 1);
    set_row(32, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    do_reset();
    for (int i = 0; i < 33; i++) begin
      req = tbl[i].req;
      flush = tbl[i].flush;
      cycle();
      chk($sformatf("tbl%0d_gnt", i), 8'(gnt0), 8'(tbl[i].g));
      chk($sformatf("tbl%0d_sel", i), 8'(sel0), 8'(tbl[i].s));
      chk($sformatf("tbl%0d_clr", i), 8'(clr0), 8'(tbl[i].c));
      chk($sformatf("tbl%0d_busy", i), 8'(busy0), 8'(tbl[i].b));
    end

    // Rotation from reset with MAX_HOLD=2.
    do_reset();
    rot_exp = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};
    req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("rot%0d_gnt", i), 8'(gnt1), 8'(rot_exp[i]));
    end

    // MAX_HOLD=1 rotates every cycle under full contention.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk($sformatf("mh1_%0d_gnt", i), 8'(gnt2), 8'(4'b0001 << (i % 4)));
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0001;
    n = 0;
    while (gnt0 !== 4'b0001 && n < 10) begin
      cycle();
      n++;
    end
    chk("midrst_wait_gnt", 8'(gnt0), 8'h01);
    clr_n = 1'b0;
    #1;
    chk("midrst_gnt", 8'(gnt0), 8'h00);
    chk("midrst_sel", 8'(sel0), 8'h00);
    chk("midrst_clr", 8'(clr0), 8'h00);
    chk("midrst_busy", 8'(busy0), 8'h00);
    model_reset();
    check_models();
    @(negedge clk);
    clr_n = 1'b1;

    // Random traffic, with one asynchronous reset partway through.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 11) == 0);
      cycle();
      if (i == 300) begin
        clr_n = 1'b0;
        #1;
        model_reset();
        check_models();
        @(negedge clk);
        clr_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
